// File: rtl/instruction_memory_responder.sv
// rtl/instruction_memory_responder.sv - fetch request/complete responder with a preloadable instruction store
module instruction_memory_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        get_instruction_i,
   input  logic [31:0] mem_address_i,
   output logic [31:0] instruction_o,
   output logic        instruction_completed_o,
   output logic        busy_o,
   output logic        error_o,
   input  logic        load_en_i,
   input  logic [31:0] load_addr_i,
   input  logic [31:0] load_data_i
);

   localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] instr_q, instr_d;
   logic        completed_q, completed_d;
   logic        error_q, error_d;

   // The store is not reset: boot contents must survive a requester reset.
   logic [31:0] store_q [DEPTH_WORDS];

   logic [31:0]      rd_offset, wr_offset;
   logic             rd_valid, wr_valid;
   logic [IDX_W-1:0] rd_idx, wr_idx;

   // Map byte addresses onto word indices; offsets wrap so addresses below the base fall out of range.
   always_comb begin
      rd_offset = addr_q - BASE_ADDR;
      wr_offset = load_addr_i - BASE_ADDR;
      rd_valid  = (addr_q[1:0] == 2'b00) && (rd_offset < SPAN);
      wr_valid  = (load_addr_i[1:0] == 2'b00) && (wr_offset < SPAN);
      rd_idx    = rd_offset[IDX_W+1:2];
      wr_idx    = wr_offset[IDX_W+1:2];
   end

   // Next-state and response logic; the store is sampled before any same-edge preload lands.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      instr_d     = instr_q;
      completed_d = completed_q;
      error_d     = error_q;
      case (state_q)
         ST_IDLE: begin
            if (get_instruction_i) begin
               addr_d  = mem_address_i;
               cnt_d   = CNT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!get_instruction_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d     = ST_HOLD;
               completed_d = 1'b1;
               if (rd_valid) begin
                  instr_d = store_q[rd_idx];
                  error_d = 1'b0;
               end else begin
                  instr_d = NOP_WORD;
                  error_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (!get_instruction_i) begin
               state_d     = ST_IDLE;
               completed_d = 1'b0;
               error_d     = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Transaction state registers; reset abandons any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         instr_q     <= '0;
         completed_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         instr_q     <= instr_d;
         completed_q <= completed_d;
         error_q     <= error_d;
      end
   end

   // Preload port writes in any state, including on a reset edge; bad addresses are dropped.
   always_ff @(posedge clk_i) begin
      if (load_en_i && wr_valid) begin
         store_q[wr_idx] <= load_data_i;
      end
   end

   assign instruction_o           = instr_q;
   assign instruction_completed_o = completed_q;
   assign error_o                 = error_q;
   assign busy_o                  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instruction_memory_responder.sv
// tb/tb_instruction_memory_responder.sv - self-checking bench for instruction_memory_responder
module tb_instruction_memory_responder;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;
   localparam int          LAT   = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, get, ld_en, done, busy, err;
   logic [31:0] addr, ld_addr, ld_data, instr;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] mdl [DEPTH];

   typedef struct {
      logic [31:0] a;
      logic [31:0] ei;
      logic        ee;
      int          hold;
   } vec_t;
   vec_t vt [8];

   always #5 clk = ~clk;

   instruction_memory_responder #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .NOP_WORD    (NOP)
   ) dut (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .get_instruction_i       (get),
      .mem_address_i           (addr),
      .instruction_o           (instr),
      .instruction_completed_o (done),
      .busy_o                  (busy),
      .error_o                 (err),
      .load_en_i               (ld_en),
      .load_addr_i             (ld_addr),
      .load_data_i             (ld_data)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b required %b", name, act, exp);
   endtask

   function automatic logic addr_ok(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a[1:0] == 2'b00) && (off < 32'(DEPTH * 4));
   endfunction

   function automatic logic [9:0] addr_idx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off[11:2];
   endfunction

   // Starts and ends at a falling edge.
   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
      if (addr_ok(a)) mdl[addr_idx(a)] = d;
   endtask

   // One full transaction: request, completion latency, stall, drop.
   task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] exp_i,
                         input logic exp_e, input int hold);
      int          n;
      logic        busy_ok, stable;
      logic [31:0] got;
      get  = 1'b1;
      addr = a;
      n = 0;
      busy_ok = 1'b1;
      do begin
         @(negedge clk);
         n++;
         addr = $urandom;
         if (busy !== 1'b1) busy_ok = 1'b0;
      end while (done !== 1'b1 && n < 20);
      chk({tag, "_latency"}, n, LAT + 1);
      chk1({tag, "_busy_wait"}, busy_ok, 1'b1);
      chk({tag, "_instr"}, instr, exp_i);
      chk1({tag, "_error"}, err, exp_e);
      got = instr;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (instr !== got || done !== 1'b1 || err !== exp_e || busy !== 1'b1) stable = 1'b0;
      end
      if (hold > 0) chk1({tag, "_hold_stable"}, stable, 1'b1);
      get = 1'b0;
      @(negedge clk);
      chk1({tag, "_drop_done"}, done, 1'b0);
      chk1({tag, "_drop_busy"}, busy, 1'b0);
      chk1({tag, "_drop_err"}, err, 1'b0);
      chk({tag, "_instr_kept"}, instr, got);
   endtask

   initial begin
      int          n;
      logic        seen;
      logic [31:0] a;
      int          r, s;
      rst = 1'b1; get = 1'b0; addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      @(negedge clk);
      @(negedge clk);
      chk1("reset_done", done, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_err", err, 1'b0);
      chk("reset_instr", instr, 32'h0);
      rst = 1'b0;

      preload(32'h8000_0000, 32'h0010_0093);
      preload(32'h8000_0004, 32'h0020_0113);
      preload(32'h8000_000C, 32'hCAFE_0003);
      preload(32'h8000_0FFC, 32'h0FFC_0FFC);
      preload(32'h8000_0001, 32'hBAD0_0001);
      preload(32'h8000_1000, 32'hBAD0_1000);
      preload(32'h7FFF_FFFC, 32'hBAD7_FFFC);

      vt[0] = '{32'h8000_0000, 32'h0010_0093, 1'b0, 5};
      vt[1] = '{32'h8000_0000, 32'h0010_0093, 1'b0, 0};
      vt[2] = '{32'h8000_0002, 32'h0000_0013, 1'b1, 1};
      vt[3] = '{32'h8000_1000, 32'h0000_0013, 1'b1, 0};
      vt[4] = '{32'h7FFF_FFFC, 32'h0000_0013, 1'b1, 2};
      vt[5] = '{32'h8000_0FFC, 32'h0FFC_0FFC, 1'b0, 0};
      vt[6] = '{32'h8000_0004, 32'h0020_0113, 1'b0, 0};
      vt[7] = '{32'h0000_0000, 32'h0000_0013, 1'b1, 0};
      for (int i = 0; i < 8; i++) do_req($sformatf("vec%0d", i), vt[i].a, vt[i].ei, vt[i].ee, vt[i].hold);

      // Abort in WAIT, then a full-latency read of word 1.
      get = 1'b1; addr = 32'h8000_0000;
      @(negedge clk);
      get = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      chk1("abort_no_done", seen, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      do_req("post_abort", 32'h8000_0004, 32'h0020_0113, 1'b0, 0);

      // Reset during WAIT never produces a completion.
      get = 1'b1; addr = 32'h8000_0000;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; get = 1'b0;
      chk1("rst_wait_busy", busy, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      chk1("rst_wait_no_done", seen, 1'b0);

      // Reset in HOLD, with a preload landing on the reset edge.
      get = 1'b1; addr = 32'h8000_0000;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 20);
      chk1("rst_hold_pre_done", done, 1'b1);
      rst = 1'b1; get = 1'b0;
      ld_en = 1'b1; ld_addr = 32'h8000_0014; ld_data = 32'h5555_0005;
      @(negedge clk);
      rst = 1'b0; ld_en = 1'b0;
      mdl[5] = 32'h5555_0005;
      chk1("rst_hold_done", done, 1'b0);
      chk1("rst_hold_busy", busy, 1'b0);
      chk1("rst_hold_err", err, 1'b0);
      chk("rst_hold_instr", instr, 32'h0);
      do_req("after_rst", 32'h8000_0000, 32'h0010_0093, 1'b0, 0);
      do_req("rst_edge_load", 32'h8000_0014, 32'h5555_0005, 1'b0, 0);

      // Preload colliding with the response sample of the same word.
      get = 1'b1; addr = 32'h8000_000C;
      @(negedge clk);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 32'h8000_000C; ld_data = 32'hDEAD_BEEF;
      @(negedge clk);
      ld_en = 1'b0;
      mdl[3] = 32'hDEAD_BEEF;
      chk1("coll_done", done, 1'b1);
      chk("coll_old_word", instr, 32'hCAFE_0003);
      get = 1'b0;
      @(negedge clk);
      do_req("coll_new_word", 32'h8000_000C, 32'hDEAD_BEEF, 1'b0, 0);

      // Randomized traffic against the array model.
      for (int i = 0; i < 32; i++) preload(BASE + 32'(i * 4), $urandom);
      for (int it = 0; it < 80; it++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2) begin
            a = BASE + 32'($urandom_range(0, 31) * 4) + ((r == 1) ? 32'($urandom_range(1, 3)) : 32'h0);
            preload(a, $urandom);
         end else if (r == 2) begin
            get = 1'b1; addr = $urandom;
            @(negedge clk);
            get = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               if (done !== 1'b0) seen = 1'b1;
            end
            chk1($sformatf("rnd%0d_abort", it), seen, 1'b0);
         end else begin
            s = int'($urandom_range(0, 5));
            if (s < 4)       a = BASE + 32'($urandom_range(0, 31) * 4);
            else if (s == 4) a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(1, 3));
            else             a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
            do_req($sformatf("rnd%0d", it), a, addr_ok(a) ? mdl[addr_idx(a)] : NOP,
                   !addr_ok(a), int'($urandom_range(0, 3)));
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
